// File: rtl/mem_arbiter2.sv
// Two-requester round-robin arbiter for a shared memory port, with a bounded hold time.
// Grants and the steer select are registered; the memory-side mux and write enable are combinational.
module mem_arbiter2 #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_HOLD   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0]      wdata0,
  input  logic [WIDTH-1:0]      wdata1,
  input  logic                  we0,
  input  logic                  we1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  sel,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic                  mem_we
);

  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state;
  state_t        next_state;
  logic          last;
  logic [CW-1:0] hold_cnt;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req0 && req1)  next_state = last ? OWN0 : OWN1;
        else if (req0)     next_state = OWN0;
        else if (req1)     next_state = OWN1;
      end
      OWN0: begin
        if (!req0)                                 next_state = req1 ? OWN1 : IDLE;
        else if ((hold_cnt == HOLD_LAST) && req1)  next_state = OWN1;
      end
      OWN1: begin
        if (!req1)                                 next_state = req0 ? OWN0 : IDLE;
        else if ((hold_cnt == HOLD_LAST) && req0)  next_state = OWN0;
      end
      default: next_state = IDLE;
    endcase
  end

  // last starts at 1 so requester 0 wins the first tie after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      sel      <= 1'b0;
      last     <= 1'b1;
      hold_cnt <= '0;
    end else begin
      state <= next_state;
      gnt0  <= (next_state == OWN0);
      gnt1  <= (next_state == OWN1);
      if (next_state != state) begin
        if (next_state == OWN0) begin
          sel      <= 1'b0;
          last     <= 1'b0;
          hold_cnt <= '0;
        end else if (next_state == OWN1) begin
          sel      <= 1'b1;
          last     <= 1'b1;
          hold_cnt <= '0;
        end
      end else if ((state != IDLE) && (hold_cnt != HOLD_LAST)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  assign mem_addr  = sel ? addr1 : addr0;
  assign mem_wdata = sel ? wdata1 : wdata0;
  assign mem_we    = (gnt0 & we0) | (gnt1 & we1);

endmodule

// File: tb/tb_mem_arbiter2.sv
// Bench for mem_arbiter2: a vector table plus hand-written multi-cycle sequences, checked through a queue.
module tb_mem_arbiter2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, sel, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        b_gnt0, b_gnt1, b_sel, b_mem_we;
  logic [15:0] b_mem_addr, b_mem_wdata;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    bit g0, g1, s;
    bit d2;
  } exp_t;

  typedef struct {
    bit r0, r1;
    bit g0, g1, s;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[12];

  always #5 clk = ~clk;

  mem_arbiter2 dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1), .gnt0(gnt0), .gnt1(gnt1), .sel(sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we)
  );

  mem_arbiter2 #(.MAX_HOLD(2)) dut2 (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1), .gnt0(b_gnt0), .gnt1(b_gnt1), .sel(b_sel),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive requests, queue the expected outcome, then compare just after the edge.
  task automatic step(input bit r0, input bit r1, input bit e0, input bit e1, input bit es,
                      input bit d2);
    exp_t e, x;
    req0 = r0;
    req1 = r1;
    e.g0 = e0; e.g1 = e1; e.s = es; e.d2 = d2;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      if (!x.d2) begin
        chk("gnt0", {31'd0, gnt0}, {31'd0, x.g0});
        chk("gnt1", {31'd0, gnt1}, {31'd0, x.g1});
        chk("sel", {31'd0, sel}, {31'd0, x.s});
        chk("mem_we", {31'd0, mem_we}, {31'd0, (x.g0 & we0) | (x.g1 & we1)});
        chk("mem_addr", {16'd0, mem_addr}, {16'd0, x.s ? addr1 : addr0});
        chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, x.s ? wdata1 : wdata0});
        chk("one_hot", {31'd0, gnt0 & gnt1}, 32'd0);
      end else begin
        chk("h2_gnt0", {31'd0, b_gnt0}, {31'd0, x.g0});
        chk("h2_gnt1", {31'd0, b_gnt1}, {31'd0, x.g1});
        chk("h2_sel", {31'd0, b_sel}, {31'd0, x.s});
        chk("h2_one_hot", {31'd0, b_gnt0 & b_gnt1}, 32'd0);
      end
    end
  endtask

  task automatic do_reset();
    req0 = 1'b0;
    req1 = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1, 0, 1, 0, 0};
    tbl[1]  = '{1, 0, 1, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 1, 1};
    tbl[4]  = '{0, 1, 0, 1, 1};
    tbl[5]  = '{0, 0, 0, 0, 1};   // idle keeps the last steer
    tbl[6]  = '{0, 1, 0, 1, 1};
    tbl[7]  = '{0, 1, 0, 1, 1};
    tbl[8]  = '{0, 1, 0, 1, 1};
    tbl[9]  = '{1, 0, 1, 0, 0};   // direct handover, no idle gap
    tbl[10] = '{0, 1, 0, 1, 1};
    tbl[11] = '{0, 0, 0, 0, 1};

    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    we0 = 1'b1; we1 = 1'b1;
    addr0 = 16'h0040; wdata0 = 16'hBEEF;
    addr1 = 16'h1234; wdata1 = 16'hCAFE;
    #1;
    chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
    chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
    chk("rst_sel", {31'd0, sel}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'h0040);
    chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'hBEEF);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      step(tbl[i].r0, tbl[i].r1, tbl[i].g0, tbl[i].g1, tbl[i].s, 1'b0);

    // Continuous tie: requester 0 first, each grant exactly 8 cycles.
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      bit own;
      own = (((k - 1) / 8) % 2) == 1;
      step(1'b1, 1'b1, !own, own, own, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Lone requester keeps the port; the saturated counter forces a handover at once.
    for (int k = 1; k <= 41; k++)
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a write grant.
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_gnt1", {31'd0, gnt1}, 32'd0);
    chk("async_sel", {31'd0, sel}, 32'd0);
    chk("async_mem_we", {31'd0, mem_we}, 32'd0);
    req0 = 1'b1;
    req1 = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Hold limit of 2: the steer toggles every two cycles.
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      bit own;
      own = (((k - 1) / 2) % 2) == 1;
      step(1'b1, 1'b1, !own, own, own, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
